// File: rtl/vending_pkg.sv
// rtl/vending_pkg.sv - shared types, price and coin tables for the vending controller
package vending_pkg;

   localparam int VEND_N = 7;
   localparam int VEND_W = 16;

   typedef enum logic [2:0] {
      S_IDLE,
      S_COLLECT,
      S_ADD,
      S_CHECK,
      S_DISPENSE,
      S_CHANGE,
      S_CLEAR
   } state_t;

   localparam int NUM_ITEMS = 4;
   localparam int PRICE [NUM_ITEMS] = '{25, 40, 65, 100};

   // Descending order; the greedy selector relies on it.
   localparam int NUM_COINS = 6;
   localparam int COIN [NUM_COINS] = '{50, 20, 10, 5, 2, 1};

endpackage

// File: rtl/vending_controller_if.sv
// rtl/vending_controller_if.sv - front-end, calculator and payout signals of the vending controller
interface vending_controller_if #(
   parameter int N = vending_pkg::VEND_N,
   parameter int W = vending_pkg::VEND_W
) ();

   logic         item_sel_valid;
   logic [1:0]   item_sel;
   logic         note_valid;
   logic [N-1:0] note_val;
   logic         note_ready;
   logic         cancel;

   logic [W-1:0] acc_value;
   logic         x_equals_y;
   logic         x_less_y;
   logic         x_greater_y;
   logic         calc_en;
   logic [N-1:0] calc_note;
   logic         calc_pulse;
   logic         calc_reset_n;

   logic [W-1:0] item_val;
   logic         dispense_valid;
   logic         dispense_ready;
   logic [1:0]   dispense_item;
   logic         change_valid;
   logic         change_ready;
   logic [W-1:0] change_coin;
   logic         busy;

   modport master (
      input  item_sel_valid, item_sel, note_valid, note_val, cancel,
      input  acc_value, x_equals_y, x_less_y, x_greater_y,
      input  dispense_ready, change_ready,
      output note_ready, calc_en, calc_note, calc_pulse, calc_reset_n,
      output item_val, dispense_valid, dispense_item, change_valid, change_coin, busy
   );

   modport slave (
      output item_sel_valid, item_sel, note_valid, note_val, cancel,
      output acc_value, x_equals_y, x_less_y, x_greater_y,
      output dispense_ready, change_ready,
      input  note_ready, calc_en, calc_note, calc_pulse, calc_reset_n,
      input  item_val, dispense_valid, dispense_item, change_valid, change_coin, busy
   );

endinterface

// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - greedy selector: largest coin not exceeding the remaining change
module change_dispenser
   import vending_pkg::*;
#(
   parameter int W = VEND_W
) (
   input  logic [W-1:0] change_rem,
   output logic [W-1:0] change_coin
);

   // Walk from the smallest coin upward so the last fit wins; zero remainder yields zero.
   always_comb begin
      change_coin = '0;
      for (int i = NUM_COINS - 1; i >= 0; i--) begin
         if (W'(COIN[i]) <= change_rem) begin
            change_coin = W'(COIN[i]);
         end
      end
   end

endmodule

// File: rtl/vending_controller.sv
// rtl/vending_controller.sv - sequencing FSM driving the money calculator, item release and coin payout
module vending_controller
   import vending_pkg::*;
#(
   parameter int N = VEND_N,
   parameter int W = VEND_W
) (
   input  logic                 clk,
   input  logic                 reset,
   vending_controller_if.master bus
);

   state_t       state;
   state_t       next_state;
   logic [W-1:0] change_rem;
   logic [W-1:0] coin;
   logic         refund;
   logic         dispense_fire;
   logic         change_fire;

   change_dispenser #(.W(W)) u_change_dispenser (
      .change_rem  (change_rem),
      .change_coin (coin)
   );

   assign dispense_fire = bus.dispense_valid & bus.dispense_ready;
   assign change_fire   = bus.change_valid & bus.change_ready;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // CHECK holds while the add pulse is in flight so the flags reflect the new total.
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE: begin
            if (bus.item_sel_valid) next_state = S_COLLECT;
         end
         S_COLLECT: begin
            if (bus.cancel)          next_state = S_CHANGE;
            else if (bus.note_valid) next_state = S_ADD;
         end
         S_ADD: begin
            next_state = S_CHECK;
         end
         S_CHECK: begin
            if (!bus.calc_pulse) next_state = bus.x_less_y ? S_COLLECT : S_DISPENSE;
         end
         S_DISPENSE: begin
            if (dispense_fire) next_state = (change_rem != '0) ? S_CHANGE : S_CLEAR;
         end
         S_CHANGE: begin
            if (refund && change_rem == '0)         next_state = S_CLEAR;
            else if (change_fire && change_rem == coin) next_state = S_CLEAR;
         end
         S_CLEAR: begin
            next_state = S_IDLE;
         end
         default: begin
            next_state = S_IDLE;
         end
      endcase
   end

   always_comb begin
      bus.note_ready     = (state == S_COLLECT);
      bus.dispense_valid = (state == S_DISPENSE);
      bus.change_valid   = (state == S_CHANGE) && (change_rem != '0);
      bus.change_coin    = bus.change_valid ? coin : '0;
      bus.busy           = (state != S_IDLE);
      bus.calc_reset_n   = reset && (state != S_CLEAR);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus.calc_en       <= 1'b0;
         bus.calc_note     <= '0;
         bus.calc_pulse    <= 1'b0;
         bus.item_val      <= '0;
         bus.dispense_item <= '0;
         change_rem        <= '0;
         refund            <= 1'b0;
      end else begin
         bus.calc_pulse <= (state == S_ADD);
         case (state)
            S_IDLE: begin
               if (bus.item_sel_valid) begin
                  bus.dispense_item <= bus.item_sel;
                  bus.item_val      <= W'(PRICE[bus.item_sel]);
               end
            end
            S_COLLECT: begin
               if (bus.cancel) begin
                  refund     <= 1'b1;
                  change_rem <= bus.acc_value;
               end else if (bus.note_valid) begin
                  bus.calc_note <= bus.note_val;
                  bus.calc_en   <= 1'b1;
               end
            end
            S_CHECK: begin
               if (!bus.calc_pulse) begin
                  bus.calc_en <= 1'b0;
                  if (!bus.x_less_y) change_rem <= bus.acc_value - bus.item_val;
               end
            end
            S_CHANGE: begin
               if (change_fire) change_rem <= change_rem - coin;
            end
            S_CLEAR: begin
               refund <= 1'b0;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: doc/vending_controller.md
# vending_controller

Sequencing FSM for the vending-machine datapath. It accepts an item selection, then admits notes one at a time into the external `money_calculator` accumulator by driving its enable, note and strobe inputs. It reads back the comparison flags, releases the item once the price is met, and pays change or a cancel refund as a stream of coin denominations. It sits between the user-facing note/button front end and the `money_calculator` instance.

## Interface
Parameters:
- `N`, 7: note value width; must match the calculator's `N`.
- `W`, 16: money width (price, accumulator, change).

Ports:
- `clk` in 1: system clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `item_sel_valid` in 1: item selection strobe; sampled only in IDLE.
- `item_sel` in 2: item index 0..3.
- `note_valid` in 1: a note is offered.
- `note_val` in N: value of the offered note.
- `note_ready` out 1: high only in COLLECT. A note is accepted when `note_valid & note_ready` on a rising edge.
- `cancel` in 1: abort request; honoured only in COLLECT.
- `acc_value` in W: calculator `accumulator_port`.
- `x_equals_y`, `x_less_y`, `x_greater_y` in 1 each: calculator compare flags.
- `calc_en` out 1: drives `money_calculator_en`.
- `calc_note` out N: drives `note_val` of the calculator.
- `calc_pulse` out 1: drives the calculator `i_valid`; registered, one cycle wide.
- `calc_reset_n` out 1: drives the calculator `reset`.
- `item_val` out W: price of the latched item.
- `dispense_valid` out 1 / `dispense_ready` in 1 / `dispense_item` out 2: item release handshake.
- `change_valid` out 1 / `change_ready` in 1 / `change_coin` out W: coin stream handshake.
- `busy` out 1: high in every state except IDLE.

## Operation
- States: IDLE, COLLECT, ADD, CHECK, DISPENSE, CHANGE, CLEAR.
- **IDLE:** when `item_sel_valid` is high, latch `item_sel` and load `item_val` = PRICE[item_sel], then go to COLLECT.
- **COLLECT:** a note handshake latches `note_val` into `calc_note`, sets `calc_en`=1 and moves to ADD.
  - `cancel` in COLLECT sets `refund`=1, loads `change_rem` = `acc_value` and moves to CHANGE.
  - If `cancel` and `note_valid` are both high, cancel wins and the note is not accepted (`note_ready` is high but the note is dropped).
- **ADD:** `calc_pulse`=1 for exactly one cycle, then go to CHECK.
- **CHECK:** `calc_en`=0.
  - `x_less_y` → COLLECT.
  - Otherwise load `change_rem` = `acc_value` − `item_val` (W-bit) and go to DISPENSE.
- **DISPENSE:** `dispense_valid`=1 and `dispense_item` = latched index. After the handshake, go to CHANGE if `change_rem`≠0, else CLEAR.
- **CHANGE:** `change_coin` = largest COIN ≤ `change_rem`; `change_valid`=1.
  - Each handshake subtracts `change_coin` from `change_rem`.
  - When the result is 0, go to CLEAR.
  - A refund with `change_rem`=0 on entry goes straight to CLEAR.
- **CLEAR:** `calc_reset_n`=0 for one cycle, clear `refund`, then go to IDLE.
- `calc_reset_n` = `reset` & (state≠CLEAR), so calculator reset tracks the system reset asynchronously.
- Overflow of the calculator accumulator is not guarded; totals stay below 2^W by construction (maximum price 100).

## Timing
- Reset values: state=IDLE. All outputs are 0 except `calc_reset_n`, which follows `reset`. `change_rem`=0, `refund`=0.
- Note accepted at edge T gives ADD in T..T+1. `calc_pulse` rises after edge T+1. CHECK samples the flags at edge T+3, so a note costs 3 cycles before COLLECT is re-entered.
- Valid/ready handshakes: `*_valid` and payload are held stable until `*_ready`. Transfer happens on an edge where both are high. No combinational path from ready to valid.
- Coin rate: at most one coin per cycle while `change_ready` is high.
- Reset asserted mid-operation: immediate return to IDLE. No dispense or coin is emitted, and the calculator is cleared in the same cycle.
- `item_sel_valid`, `note_valid` and `cancel` are ignored in every state not listed above.

## Structure
- Package `vending_pkg` holds:
  - state enum;
  - PRICE[0:3] = 25, 40, 65, 100;
  - COIN list, descending = 50, 20, 10, 5, 2, 1;
  - widths `N` and `W`.
- Sub-module `change_dispenser`: combinational greedy coin selector (`change_rem` → `change_coin`). The FSM owns the `change_rem` register and the handshake.

## Test plan
- Exact payment: select item 0 (25), notes 20 then 5 → one dispense of item 0, no coins, `calc_reset_n` low for 1 cycle, back to IDLE.
- Overpay: select item 1 (40), note 100 → dispense item 1, then coins 50, 10 in order, `change_rem` reaches 0, IDLE.
- Cancel: select item 3, notes 50, 20, then `cancel` → no dispense, coins 50, 20, calculator cleared.
- Backpressure: item 2 (65), note 100 with `change_ready` toggling every other cycle → coins 20, 10, 5, each held stable while ready is low; `dispense_ready` held low 5 cycles → FSM stays in DISPENSE.
- Collisions: `cancel` and `note_valid` in the same COLLECT cycle → no `calc_pulse`, refund of the prior total only. A note offered during ADD/CHECK → `note_ready`=0, not counted.
- Reset mid-CHANGE: assert `reset` after the first coin → all outputs 0 at once, `calc_reset_n`=0, IDLE after release, no further coins.
